// File: rtl/uart_frame_writer.sv
// Buffers payload bytes and, on send, writes one SOF/LEN/payload/CHK frame
// into the UART core's transmit port, pacing every byte on txrdy.
module uart_frame_writer #(
  parameter int unsigned DEPTH    = 16,
  parameter logic [7:0]  SOF_BYTE = 8'hAA,
  parameter int unsigned HOLDOFF  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               wr_data,
  input  logic                     wr_en,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     send,
  output logic                     busy,
  output logic                     done,
  input  logic                     txrdy,
  output logic [7:0]               data_in,
  output logic                     wen
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_WRITE,
    ST_HOLD,
    ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    PH_SOF,
    PH_LEN,
    PH_PAY,
    PH_CHK,
    PH_END
  } phase_t;

  state_t          state_q, state_d;
  phase_t          phase_q, phase_d;
  logic [2:0]      hold_q, hold_d;
  logic [CW-1:0]   left_q, left_d;
  logic [CW-1:0]   len_q, len_d;
  logic [7:0]      chk_q, chk_d;
  logic [7:0]      data_q, data_d;
  logic [7:0]      len_byte;
  logic [7:0]      next_byte;
  logic            pop;

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count_q, count_d;
  logic            full_q;
  logic            ovf_q;
  logic            push;

  always_comb begin
    len_byte = '0;
    len_byte[CW-1:0] = len_q;
  end

  always_comb begin
    next_byte = chk_q;
    case (phase_q)
      PH_SOF:  next_byte = SOF_BYTE;
      PH_LEN:  next_byte = len_byte;
      PH_PAY:  next_byte = mem[rd_ptr];
      default: next_byte = chk_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      phase_q <= PH_SOF;
      hold_q  <= '0;
      left_q  <= '0;
      len_q   <= '0;
      chk_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      hold_q  <= hold_d;
      left_q  <= left_d;
      len_q   <= len_d;
      chk_q   <= chk_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    hold_d  = hold_q;
    left_d  = left_q;
    len_d   = len_q;
    chk_d   = chk_q;
    data_d  = data_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (send) begin
          len_d   = count_q;
          left_d  = count_q;
          chk_d   = '0;
          phase_d = PH_SOF;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (txrdy) begin
          data_d  = next_byte;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        hold_d  = '0;
        state_d = ST_HOLD;
        // Phase advances here so the HOLD window already knows what comes next.
        case (phase_q)
          PH_SOF: phase_d = PH_LEN;
          PH_LEN: begin
            chk_d   = chk_q ^ data_q;
            phase_d = (len_q == '0) ? PH_CHK : PH_PAY;
          end
          PH_PAY: begin
            pop     = 1'b1;
            chk_d   = chk_q ^ data_q;
            left_d  = left_q - CW'(1);
            phase_d = (left_q == CW'(1)) ? PH_CHK : PH_PAY;
          end
          default: phase_d = PH_END;
        endcase
      end
      ST_HOLD: begin
        if (hold_q == 3'(HOLDOFF - 1)) begin
          state_d = (phase_q == PH_END) ? ST_DONE : ST_WAIT;
        end else begin
          hold_d = hold_q + 3'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign push = wr_en && !full_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      if (wr_en && full_q) ovf_q <= 1'b1;
    end
  end

  assign full     = full_q;
  assign count    = count_q;
  assign overflow = ovf_q;
  assign data_in  = data_q;
  assign wen      = (state_q != ST_WRITE);
  assign busy     = (state_q == ST_WAIT) || (state_q == ST_WRITE) || (state_q == ST_HOLD);
  assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_uart_frame_writer.sv
// Bench for uart_frame_writer: UART-core model, queue-based frame model, directed and random frames.
module tb_uart_frame_writer;

  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full;
  logic [4:0] count;
  logic       overflow;
  logic       send;
  logic       busy;
  logic       done;
  logic       txrdy;
  logic [7:0] data_in;
  logic       wen;

  uart_frame_writer #(.DEPTH(DEPTH), .SOF_BYTE(8'hAA), .HOLDOFF(2)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .full(full),
    .count(count), .overflow(overflow), .send(send), .busy(busy), .done(done),
    .txrdy(txrdy), .data_in(data_in), .wen(wen)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic uart_ready = 1'b1;
  logic hold_low   = 1'b0;
  int   uart_delay = 10;
  int   uart_cnt   = 0;
  assign txrdy = uart_ready && !hold_low;

  initial begin
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        uart_ready = 1'b1;
        uart_cnt   = 0;
      end else if (wen == 1'b0) begin
        uart_ready = 1'b0;
        uart_cnt   = uart_delay;
      end else if (uart_cnt > 0) begin
        uart_cnt--;
        if (uart_cnt == 0) uart_ready = 1'b1;
      end
    end
  end

  logic [7:0] cap[$];
  int         cap_cyc[$];
  int         done_cnt = 0;
  int         wide_err = 0;
  int         busy_done_err = 0;
  logic       prev_low = 1'b0;

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (!wen) begin
        cap.push_back(data_in);
        cap_cyc.push_back(cyc);
        if (prev_low) wide_err++;
      end
      if (done) begin
        done_cnt++;
        if (busy) busy_done_err++;
      end
      prev_low = !wen;
    end else begin
      prev_low = 1'b0;
    end
  end

  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  logic       movf = 1'b0;
  int         send_cyc;

  task automatic wr_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    if (mq.size() < DEPTH) mq.push_back(b);
    else movf = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic start_frame();
    int len;
    logic [7:0] chk;
    logic [7:0] b;
    cap.delete();
    cap_cyc.delete();
    done_cnt = 0;
    wide_err = 0;
    busy_done_err = 0;
    send = 1'b1;
    send_cyc = cyc;
    @(negedge clk);
    send = 1'b0;
    exp_q.delete();
    len = mq.size();
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'(len));
    chk = 8'(len);
    for (int i = 0; i < len; i++) begin
      b = mq.pop_front();
      exp_q.push_back(b);
      chk ^= b;
    end
    exp_q.push_back(chk);
  endtask

  task automatic wait_cap(input string tag, input int n);
    int k = 0;
    while (cap.size() < n && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (cap.size() < n) check({tag, "_wait_timeout"}, cap.size(), n);
  endtask

  task automatic finish_frame(input string tag);
    int k = 0;
    int n;
    while (done_cnt == 0 && k < 4000) begin
      @(negedge clk);
      k++;
    end
    if (done_cnt == 0) check({tag, "_done_timeout"}, 0, 1);
    repeat (4) @(negedge clk);
    check({tag, "_nbytes"}, cap.size(), exp_q.size());
    n = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_byte%0d", tag, i), cap[i], exp_q[i]);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_wen_width"}, wide_err, 0);
    check({tag, "_busy_at_done"}, busy_done_err, 0);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_count"}, count, mq.size());
    check({tag, "_full"}, full, (mq.size() == DEPTH));
    check({tag, "_overflow"}, overflow, movf);
  endtask

  initial begin
    int n;
    int rel_cyc;
    rst = 1'b0; wr_en = 1'b0; wr_data = '0; send = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data_in", data_in, 0);
    check("rst_wen", wen, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_count", count, 0);
    rst = 1'b1;
    @(negedge clk);

    // 1: basic three-byte frame
    wr_byte(8'h01); wr_byte(8'h02); wr_byte(8'h03);
    check("t1_count", count, 3);
    start_frame();
    wait_cap("t1", 1);
    if (cap_cyc.size() > 0) check("t1_latency", cap_cyc[0] - send_cyc, 2);
    finish_frame("t1");

    // 2: empty frame
    start_frame();
    finish_frame("t2");

    // 3: fill past capacity
    for (int i = 0; i < 16; i++) wr_byte(8'(i));
    check("t3_full16", full, 1);
    check("t3_ovf16", overflow, 0);
    wr_byte(8'h10);
    check("t3_ovf17", overflow, 1);
    check("t3_count17", count, 16);
    start_frame();
    finish_frame("t3");
    check("t3_chk", cap.size() > 0 ? cap[cap.size()-1] : 8'h00, 8'h10);

    // 4: txrdy stall after LEN
    wr_byte(8'h3C); wr_byte(8'hC3); wr_byte(8'h99);
    start_frame();
    wait_cap("t4", 2);
    hold_low = 1'b1;
    repeat (50) @(negedge clk);
    check("t4_stalled", cap.size(), 2);
    check("t4_wen_stall", wen, 1);
    rel_cyc = cyc;
    hold_low = 1'b0;
    wait_cap("t4r", 3);
    if (cap_cyc.size() > 2) check("t4_resume_lat", cap_cyc[2] - rel_cyc, 1);
    finish_frame("t4");

    // 5: send ignored while busy, writes queued for next frame
    wr_byte(8'h11); wr_byte(8'h22); wr_byte(8'h33);
    start_frame();
    repeat (15) @(negedge clk);
    check("t5_busy", busy, 1);
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    wr_byte(8'hAA); wr_byte(8'hBB);
    finish_frame("t5a");
    check("t5_count2", count, 2);
    start_frame();
    finish_frame("t5b");
    check("t5_chk13", cap.size() > 0 ? cap[cap.size()-1] : 8'h00, 8'h13);

    // 6: reset mid-payload
    wr_byte(8'h44); wr_byte(8'h55); wr_byte(8'h66);
    start_frame();
    wait_cap("t6", 3);
    #2 rst = 1'b0;
    #1;
    check("t6_wen", wen, 1);
    check("t6_busy", busy, 0);
    check("t6_count", count, 0);
    check("t6_overflow", overflow, 0);
    @(negedge clk);
    rst = 1'b1;
    mq.delete();
    movf = 1'b0;
    @(negedge clk);
    wr_byte(8'h5A);
    start_frame();
    finish_frame("t6b");
    check("t6_chk5b", cap.size() > 0 ? cap[cap.size()-1] : 8'h00, 8'h5B);

    // random frames with random UART pacing
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(0, DEPTH + 3);
      for (int j = 0; j < n; j++) begin
        wr_byte(8'($urandom));
        if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
      uart_delay = $urandom_range(1, 12);
      start_frame();
      finish_frame($sformatf("rnd%0d", it));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
